mips_instr_encoder: RTL and testbench
=====================================

// Module: mips_instr_encoder
// PURPOSE
//  Inverse of the main decoder: turns a stream of mnemonic commands (op enum + fields) into
//  32-bit MIPS instruction words and writes them sequentially into instruction memory.
//  Used by the boot/self-test loader to build programs at run time.
//  Sits between the loader command source and the imem write port.
// PARAMETERS
//  ADDR_W     6   imem word-address width; address wraps modulo 2**ADDR_W
//  BASE_ADDR  0   first word address written after start
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: begin a new program at BASE_ADDR
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       encoder accepts the command this cycle
//  cmd_op       in   5       enc_op_e mnemonic
//  cmd_rs       in   5       rs field
//  cmd_rt       in   5       rt field
//  cmd_rd       in   5       rd field
//  cmd_imm      in   16      immediate / branch offset
//  cmd_target   in   26      jump target
//  cmd_last     in   1       final command of the program
//  imem_we      out  1       write strobe; memory always accepts
//  imem_addr    out  ADDR_W  word address
//  imem_wdata   out  32      encoded instruction
//  busy         out  1       state != IDLE && state != DONE
//  done         out  1       high in DONE
//  err          out  1       sticky: illegal cmd_op was encoded
//  wrap         out  1       sticky: imem_addr wrapped past 2**ADDR_W-1
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, imem_addr=BASE_ADDR; all other outputs 0.
//  FSM: IDLE -start-> RUN. RUN: after the cmd_last word is written and FIFO is empty -> DONE.
//   DONE -start-> RUN. start clears err, wrap and the FIFO and loads imem_addr=BASE_ADDR.
//   start in RUN restarts the same way; in-flight commands are discarded.
//  cmd_ready = (state==RUN) && FIFO not full && !last_seen. Handshake: cmd_valid && cmd_ready.
//   Commands arriving after cmd_last are not accepted until the next start.
//  2-entry FIFO of encoded words. Encoding happens on accept.
//   Accept in cycle N -> imem_we in cycle N+1 at earliest. Throughput is 1 word/cycle.
//   Simultaneous push and pop on a full FIFO is allowed.
//  imem_addr increments by 1 after each write. At 2**ADDR_W-1 it wraps to 0 and sets wrap.
//  Encoding: R-type op=0: {0,rs,rt,rd,5'b0,funct}.
//   Funct codes: ADD 20, SUB 22, AND 24, OR 25, SLT 2A, MULT 18, DIV 1A, MFHI 10, MFLO 12, JR 08.
//   MULT/DIV use rd=0. MFHI/MFLO use rs=rt=0. JR uses rt=rd=0.
//  I-type: {op,rs,rt,imm}.
//   Opcodes: LW 23, LB 20, SW 2B, SB 28, BEQ 04, BNE 05, ADDI 08, SLTI 0A.
//  J-type: {op,target}. Opcodes: J 02, JAL 03.
//  Illegal enum value: writes 32'h0 (NOP) and sets err. Encoding and addressing continue.
//  reset_n low mid-program: everything returns immediately to reset values.
// CONFIGURATION
//  ENC_DELAY_SLOT_EN defined:
//   After each BEQ/BNE/J/JAL/JR word, the FSM enters PAD for exactly 1 cycle.
//   In PAD it writes NOP 32'h0 at the next address and holds cmd_ready=0.
//   If the padded word is the cmd_last word, DONE follows PAD.
//  ENC_DELAY_SLOT_EN undefined: no PAD state; branches are written back-to-back.
// STRUCTURE
//  Package mips_enc_pkg holds:
//   - enc_op_e (5-bit mnemonic enum)
//   - opcode/funct localparams shared with the main decoder
//   - state_e {IDLE,RUN,PAD,DONE}
//  Sub-module mips_enc_fifo: 2-deep, 33-bit FIFO (word + last flag) with full/empty.
//  Encoding is a combinational function in the package (encode_instr).
// TESTING
//  ADD rs=1 rt=2 rd=3 -> imem_wdata=32'h00221820 at addr 0, one cycle after accept.
//  LW rs=29 rt=8 imm=4, then MULT rs=4 rt=5 -> 32'h8FA80004 @0, 32'h00850018 @1.
//  J target=26'h10 with cmd_last -> 32'h08000010; done=1 next cycle; cmd_ready=0 afterwards.
//  BEQ rs=1 rt=2 imm=FFFF, then ADD; DELAY_SLOT_EN on -> 1022FFFF @0, NOP @1, ADD @2.
//   Same sequence with DELAY_SLOT_EN off -> ADD @1.
//  ADDR_W=2, 5 commands -> addresses 0,1,2,3,0; wrap=1. Illegal op 31 -> word 0, err=1.
//  reset_n low during RUN with FIFO full -> imem_we=0 and cmd_ready=0 immediately.
//   start after reset -> first write lands at BASE_ADDR.

Source files
------------

// File: rtl/mips_enc_pkg.sv
// Shared encoder definitions: mnemonic enum, MIPS opcode/funct codes, FSM states
// and the combinational instruction encoder.
package mips_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SLT  = 5'd4,
        OP_MULT = 5'd5,
        OP_DIV  = 5'd6,
        OP_MFHI = 5'd7,
        OP_MFLO = 5'd8,
        OP_JR   = 5'd9,
        OP_LW   = 5'd10,
        OP_LB   = 5'd11,
        OP_SW   = 5'd12,
        OP_SB   = 5'd13,
        OP_BEQ  = 5'd14,
        OP_BNE  = 5'd15,
        OP_ADDI = 5'd16,
        OP_SLTI = 5'd17,
        OP_J    = 5'd18,
        OP_JAL  = 5'd19
    } enc_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_LB    = 6'h20;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SB    = 6'h28;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] r_type(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] funct
    );
        return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_JAL;
    endfunction

    // Control-transfer words are recognised from the encoded word itself so the
    // FIFO only has to carry the word and its last flag.
    function automatic logic is_ctrl_word(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OPC_BEQ) || (opcode == OPC_BNE) || (opcode == OPC_J) ||
               (opcode == OPC_JAL) || ((opcode == OPC_RTYPE) && (funct == FN_JR));
    endfunction

    function automatic logic [31:0] encode_instr(
        input logic [4:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        word = NOP_WORD;
        case (op)
            OP_ADD:  word = r_type(rs, rt, rd, FN_ADD);
            OP_SUB:  word = r_type(rs, rt, rd, FN_SUB);
            OP_AND:  word = r_type(rs, rt, rd, FN_AND);
            OP_OR:   word = r_type(rs, rt, rd, FN_OR);
            OP_SLT:  word = r_type(rs, rt, rd, FN_SLT);
            OP_MULT: word = r_type(rs, rt, 5'd0, FN_MULT);
            OP_DIV:  word = r_type(rs, rt, 5'd0, FN_DIV);
            OP_MFHI: word = r_type(5'd0, 5'd0, rd, FN_MFHI);
            OP_MFLO: word = r_type(5'd0, 5'd0, rd, FN_MFLO);
            OP_JR:   word = r_type(rs, 5'd0, 5'd0, FN_JR);
            OP_LW:   word = {OPC_LW, rs, rt, imm};
            OP_LB:   word = {OPC_LB, rs, rt, imm};
            OP_SW:   word = {OPC_SW, rs, rt, imm};
            OP_SB:   word = {OPC_SB, rs, rt, imm};
            OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
            OP_BNE:  word = {OPC_BNE, rs, rt, imm};
            OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
            OP_SLTI: word = {OPC_SLTI, rs, rt, imm};
            OP_J:    word = {OPC_J, target};
            OP_JAL:  word = {OPC_JAL, target};
            default: word = NOP_WORD;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/mips_enc_fifo.sv
// Two-entry FIFO holding encoded words plus their last flag; supports push and
// pop in the same cycle even when full, and a synchronous clear.
module mips_enc_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && !clear && (wr_ptr_q == 1'(gi))) begin
                mem_q[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/mips_instr_encoder.sv
// Loader-side MIPS encoder: mnemonic commands in, sequential imem writes out.
// Optional ENC_DELAY_SLOT_EN inserts a NOP after every branch/jump word.
module mips_instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wrap
);
    import mips_enc_pkg::*;

    localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;
    logic              last_seen_q, last_seen_d;
    logic              pad_last_q, pad_last_d;

    logic              cmd_accept;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [32:0]       fifo_wdata;
    logic [32:0]       fifo_rdata;
    logic [31:0]       head_word;
    logic              head_last;

    assign cmd_ready  = (state_q == RUN) && !fifo_full && !last_seen_q;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_last, encode_instr(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target)};
    assign head_word  = fifo_rdata[31:0];
    assign head_last  = fifo_rdata[32];
    assign fifo_pop   = (state_q == RUN) && !fifo_empty;

    mips_enc_fifo #(
        .WIDTH (33)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .push    (cmd_accept),
        .wdata   (fifo_wdata),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The pad slot writes a NOP without consuming the FIFO head.
    assign imem_we    = fifo_pop || (state_q == PAD);
    assign imem_wdata = fifo_pop ? head_word : NOP_WORD;
    assign imem_addr  = addr_q;
    assign busy       = (state_q == RUN) || (state_q == PAD);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign wrap       = wrap_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        err_d       = err_q;
        wrap_d      = wrap_q;
        last_seen_d = last_seen_q;
        pad_last_d  = pad_last_q;

        if (imem_we) begin
            addr_d = addr_q + 1'b1;
            if (addr_q == ADDR_MAX) begin
                wrap_d = 1'b1;
            end
        end

        if (cmd_accept) begin
            if (cmd_last) begin
                last_seen_d = 1'b1;
            end
            if (!op_is_legal(cmd_op)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (fifo_pop) begin
`ifdef ENC_DELAY_SLOT_EN
                    if (is_ctrl_word(head_word[31:26], head_word[5:0])) begin
                        state_d    = PAD;
                        pad_last_d = head_last;
                    end else if (head_last) begin
                        state_d = DONE;
                    end
`else
                    if (head_last) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            PAD:     state_d = pad_last_q ? DONE : RUN;
            default: state_d = state_q;
        endcase

        // start restarts from any state and discards whatever is in flight.
        if (start) begin
            state_d     = RUN;
            addr_d      = BASE_WORD;
            err_d       = 1'b0;
            wrap_d      = 1'b0;
            last_seen_d = 1'b0;
            pad_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= BASE_WORD;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            last_seen_q <= 1'b0;
            pad_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
            last_seen_q <= last_seen_d;
            pad_last_q  <= pad_last_d;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder (ADDR_W=2 to exercise address wrap);
// expectations follow ENC_DELAY_SLOT_EN when it is defined.
module tb_mips_instr_encoder;
    import mips_enc_pkg::*;

    localparam int ADDR_W = 2;
`ifdef ENC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              start      = 1'b0;
    logic              cmd_valid  = 1'b0;
    logic              cmd_last   = 1'b0;
    logic [4:0]        cmd_op     = 5'd0;
    logic [4:0]        cmd_rs     = 5'd0;
    logic [4:0]        cmd_rt     = 5'd0;
    logic [4:0]        cmd_rd     = 5'd0;
    logic [15:0]       cmd_imm    = 16'd0;
    logic [25:0]       cmd_target = 26'd0;
    logic              cmd_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              wrap;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] log_addr [$];
    logic [31:0]       log_data [$];

    always #5 clk = ~clk;

    mips_instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_rd     (cmd_rd),
        .cmd_imm    (cmd_imm),
        .cmd_target (cmd_target),
        .cmd_last   (cmd_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wrap       (wrap)
    );

    always @(negedge clk) begin
        if (imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic send(input string tag, input logic [4:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        bit acc;
        acc        = 1'b0;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_rs     = rs;
        cmd_rt     = rt;
        cmd_rd     = rd;
        cmd_imm    = imm;
        cmd_target = tgt;
        cmd_last   = last;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        if (!acc) chk({tag, "_accept"}, 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tick();
        chk({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        logic [31:0] a;
        logic [31:0] d;
        a = 32'hFFFF_FFFF;
        d = 32'hFFFF_FFFF;
        if (idx < log_data.size()) begin
            a = 32'(log_addr[idx]);
            d = log_data[idx];
        end
        chk({tag, "_addr"}, a, exp_addr);
        chk({tag, "_data"}, d, exp_data);
    endtask

    task automatic run_single(input string tag, input logic [4:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                              input logic [25:0] tgt, input logic [31:0] exp_word);
        do_start();
        send(tag, op, rs, rt, rd, imm, tgt, 1'b1);
        wait_done(tag);
        chk_log(tag, 0, 32'd0, exp_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen_ready;
        int seen_we;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_ready", 32'(cmd_ready), 32'd0);

        // ADD: written one cycle after accept at addr 0
        do_start();
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_ready", 32'(cmd_ready), 32'd1);
        send("add", OP_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
        chk("add_we", 32'(imem_we), 32'd1);
        chk("add_addr", 32'(imem_addr), 32'd0);
        chk("add_data", imem_wdata, 32'h0022_1820);
        chk("add_ready_after_last", 32'(cmd_ready), 32'd0);
        tick();
        chk("add_done", 32'(done), 32'd1);
        chk("add_busy", 32'(busy), 32'd0);

        // LW then MULT back to back
        do_start();
        send("lw", OP_LW, 5'd29, 5'd8, 5'd0, 16'd4, 26'd0, 1'b0);
        chk("lw_data", imem_wdata, 32'h8FA8_0004);
        chk("lw_addr", 32'(imem_addr), 32'd0);
        send("mult", OP_MULT, 5'd4, 5'd5, 5'd9, 16'd0, 26'd0, 1'b1);
        chk("mult_data", imem_wdata, 32'h0085_0018);
        chk("mult_addr", 32'(imem_addr), 32'd1);
        wait_done("mult");

        // J as last command, then nothing more is accepted
        do_start();
        send("j", OP_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1);
        chk("j_data", imem_wdata, 32'h0800_0010);
        chk("j_addr", 32'(imem_addr), 32'd0);
        tick();
        chk("j_next_done", 32'(done), DS ? 32'd0 : 32'd1);
        chk("j_next_we", 32'(imem_we), DS ? 32'd1 : 32'd0);
        chk("j_next_wdata", imem_wdata, 32'd0);
        wait_done("j");
        seen_ready = 0;
        seen_we    = 0;
        cmd_valid  = 1'b1;
        cmd_op     = OP_ADD;
        repeat (3) begin
            @(negedge clk);
            if (cmd_ready) seen_ready++;
            if (imem_we) seen_we++;
        end
        tick();
        cmd_valid = 1'b0;
        chk("j_no_accept", 32'(seen_ready), 32'd0);
        chk("j_no_write", 32'(seen_we), 32'd0);
        chk("j_log_size", 32'(log_data.size()), DS ? 32'd2 : 32'd1);

        // BEQ then ADD: delay slot padding
        do_start();
        send("beq", OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0);
        send("beq_add", OP_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
        wait_done("beq");
        chk("beq_log_size", 32'(log_data.size()), DS ? 32'd3 : 32'd2);
        chk_log("beq_w0", 0, 32'd0, 32'h1022_FFFF);
        chk_log("beq_w1", 1, 32'd1, DS ? 32'd0 : 32'h0022_1820);
        chk_log("beq_wadd", DS ? 2 : 1, DS ? 32'd2 : 32'd1, 32'h0022_1820);

        // Address wrap with ADDR_W=2
        do_start();
        for (int i = 0; i < 5; i++) begin
            send("wrap_cmd", OP_ADD, 5'(i), 5'(i), 5'(i + 1), 16'd0, 26'd0, 1'(i == 4));
        end
        wait_done("wrap");
        chk("wrap_log_size", 32'(log_data.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk_log("wrap_w", i, 32'(i % 4),
                    {6'd0, 5'(i), 5'(i), 5'(i + 1), 5'd0, 6'h20});
        end
        chk("wrap_flag", 32'(wrap), 32'd1);
        chk("wrap_err", 32'(err), 32'd0);

        // Illegal op: NOP word, err set; start clears err and wrap
        do_start();
        chk("ill_wrap_cleared", 32'(wrap), 32'd0);
        send("ill", 5'd31, 5'd5, 5'd6, 5'd7, 16'h1234, 26'h0ABCDEF, 1'b1);
        wait_done("ill");
        chk_log("ill_w0", 0, 32'd0, 32'd0);
        chk("ill_err", 32'(err), 32'd1);
        do_start();
        chk("ill_err_cleared", 32'(err), 32'd0);
        send("ill2", 5'd20, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1, 1'b0);
        send("ill2_add", OP_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
        wait_done("ill2");
        chk_log("ill2_w0", 0, 32'd0, 32'd0);
        chk_log("ill2_w1", 1, 32'd1, 32'h0022_1820);
        chk("ill2_err", 32'(err), 32'd1);

        // Remaining encodings
        run_single("sub",  OP_SUB,  5'd1,  5'd2,  5'd3, 16'd0,     26'd0,       32'h0022_1822);
        run_single("and",  OP_AND,  5'd1,  5'd2,  5'd3, 16'd0,     26'd0,       32'h0022_1824);
        run_single("or",   OP_OR,   5'd1,  5'd2,  5'd3, 16'd0,     26'd0,       32'h0022_1825);
        run_single("slt",  OP_SLT,  5'd10, 5'd11, 5'd9, 16'd0,     26'd0,       32'h014B_482A);
        run_single("div",  OP_DIV,  5'd6,  5'd7,  5'd9, 16'd0,     26'd0,       32'h00C7_001A);
        run_single("mfhi", OP_MFHI, 5'd7,  5'd7,  5'd5, 16'd0,     26'd0,       32'h0000_2810);
        run_single("mflo", OP_MFLO, 5'd7,  5'd7,  5'd4, 16'd0,     26'd0,       32'h0000_2012);
        run_single("jr",   OP_JR,   5'd31, 5'd3,  5'd3, 16'd0,     26'd0,       32'h03E0_0008);
        run_single("lb",   OP_LB,   5'd0,  5'd2,  5'd0, 16'h0010,  26'd0,       32'h8002_0010);
        run_single("sw",   OP_SW,   5'd2,  5'd3,  5'd0, 16'h0008,  26'd0,       32'hAC43_0008);
        run_single("sb",   OP_SB,   5'd1,  5'd2,  5'd0, 16'h0000,  26'd0,       32'hA022_0000);
        run_single("bne",  OP_BNE,  5'd1,  5'd0,  5'd0, 16'h0003,  26'd0,       32'h1420_0003);
        run_single("addi", OP_ADDI, 5'd1,  5'd1,  5'd0, 16'h0005,  26'd0,       32'h2021_0005);
        run_single("slti", OP_SLTI, 5'd3,  5'd4,  5'd0, 16'h0007,  26'd0,       32'h2864_0007);
        run_single("jal",  OP_JAL,  5'd0,  5'd0,  5'd0, 16'd0,     26'h0123456, 32'h0C12_3456);

        // Asynchronous reset mid-program
        do_start();
        send("rst_beq", OP_BEQ, 5'd1, 5'd2, 5'd0, 16'h0001, 26'd0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        cmd_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_idle_busy", 32'(busy), 32'd0);
        do_start();
        send("arst_add", OP_ADD, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b1);
        chk("arst_add_addr", 32'(imem_addr), 32'd0);
        chk("arst_add_data", imem_wdata, 32'h0085_3020);
        wait_done("arst_add");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
